fifo_rd_stream_bridge: RTL and testbench

- Read-side consumer that sits directly downstream of the team's asynchronous FIFO, in the FIFO read-clock domain.
- Drives the FIFO read enable and captures FIFO read data, which appears one cycle after the read enable.
- Re-presents the data as a valid/ready stream with packet framing: o_m_last on every P_PKT_LEN-th beat.
- A 3-entry internal buffer absorbs the FIFO read latency, so the block sustains 1 beat/cycle with no combinational path from i_m_ready to o_fifo_rd_en.

---
 rtl/fifo_rd_stream_bridge.sv | 85 ++++++++
 tb/tb_fifo_rd_stream_bridge.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_bridge.sv
// Read-side bridge from the async FIFO into a framed valid/ready stream.
// A 3-entry buffer covers the one-cycle FIFO read latency so reads never wait on downstream ready.
module fifo_rd_stream_bridge #(
    parameter int P_DATA_WIDTH = 4,
    parameter int P_PKT_LEN    = 16,
    parameter int P_PCNT_WIDTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_fifo_rempty,
    output logic                    o_fifo_rd_en,
    input  logic [P_DATA_WIDTH-1:0] i_fifo_rdata,
    output logic                    o_m_valid,
    output logic [P_DATA_WIDTH-1:0] o_m_data,
    output logic                    o_m_last,
    input  logic                    i_m_ready,
    output logic [P_PCNT_WIDTH-1:0] o_pkt_cnt
);

    localparam int BCW = (P_PKT_LEN > 1) ? $clog2(P_PKT_LEN) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(P_PKT_LEN - 1);

    logic [P_DATA_WIDTH-1:0] mem [3];
    logic [1:0]              wr_ptr;
    logic [1:0]              rd_ptr;
    logic [1:0]              occ;
    logic                    inflight;
    logic                    run;
    logic [BCW-1:0]          beat_cnt;
    logic [P_PCNT_WIDTH-1:0] pkt_cnt;
    logic [2:0]              pending;
    logic                    pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Slots already claimed: stored words plus the word returning from the FIFO this cycle.
    // run keeps the read enable low while reset is held and until the first edge after release.
    assign pending      = {1'b0, occ} + {2'b00, inflight};
    assign o_fifo_rd_en = run && !i_fifo_rempty && (pending < 3'd3);

    // Stream handshake: a beat transfers on a rising edge where o_m_valid and i_m_ready are both 1;
    // o_m_valid never depends on i_m_ready, and data/last hold while valid waits for ready.
    assign o_m_valid = (occ != 2'd0);
    assign o_m_data  = mem[rd_ptr];
    assign o_m_last  = o_m_valid && (beat_cnt == LAST_BEAT);
    assign pop       = o_m_valid && i_m_ready;
    assign o_pkt_cnt = pkt_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 3; i++) mem[i] <= '0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            run      <= 1'b0;
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            run      <= 1'b1;
            inflight <= o_fifo_rd_en;
            if (inflight) begin
                mem[wr_ptr] <= i_fifo_rdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
                if (o_m_last) begin
                    beat_cnt <= '0;
                    pkt_cnt  <= pkt_cnt + 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            case ({inflight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_bridge.sv
// Bench for fifo_rd_stream_bridge: a behavioural FIFO feeds the DUT, expected beats go to a scoreboard queue.
module tb_fifo_rd_stream_bridge;

    localparam int W  = 4;
    localparam int EW = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rempty = 1'b1;
    logic         rd_en, valid, last;
    logic         ready = 1'b0;
    logic [W-1:0] rdata = '0;
    logic [W-1:0] data;
    logic [15:0]  pkt;

    logic         rempty1 = 1'b1;
    logic         rd_en1, valid1, last1;
    logic         ready1 = 1'b1;
    logic [W-1:0] rdata1 = '0;
    logic [W-1:0] data1;
    logic [15:0]  pkt1;

    always #5 clk = ~clk;

    fifo_rd_stream_bridge #(.P_DATA_WIDTH(W), .P_PKT_LEN(16), .P_PCNT_WIDTH(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_fifo_rempty(rempty), .o_fifo_rd_en(rd_en),
        .i_fifo_rdata(rdata), .o_m_valid(valid), .o_m_data(data), .o_m_last(last),
        .i_m_ready(ready), .o_pkt_cnt(pkt)
    );

    fifo_rd_stream_bridge #(.P_DATA_WIDTH(W), .P_PKT_LEN(1), .P_PCNT_WIDTH(16)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_fifo_rempty(rempty1), .o_fifo_rd_en(rd_en1),
        .i_fifo_rdata(rdata1), .o_m_valid(valid1), .o_m_data(data1), .o_m_last(last1),
        .i_m_ready(ready1), .o_pkt_cnt(pkt1)
    );

    logic [W-1:0]  fifo_q[$];
    logic [W-1:0]  fifo1_q[$];
    logic [EW-1:0] exp_q[$];
    logic          gap = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            push_idx = 0;
    int            rd_while_empty = 0;
    int            over_cnt = 0;
    int            outstanding = 0;
    int            rd_pulses = 0;

    // FIFO model: read data appears the cycle after rd_en; empty flag settles shortly after each edge.
    always @(posedge clk) begin
        cyc++;
        if (rd_en && rempty) rd_while_empty++;
        if (rd_en1 && rempty1) rd_while_empty++;
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            outstanding = outstanding + int'(rd_en) - int'(valid && ready);
            if (outstanding > 3) over_cnt++;
        end
        if (rd_en) begin
            rd_pulses++;
            if (fifo_q.size() > 0) rdata <= fifo_q.pop_front();
        end
        if (rd_en1 && fifo1_q.size() > 0) rdata1 <= fifo1_q.pop_front();
        #2;
        rempty  = gap || (fifo_q.size() == 0);
        rempty1 = (fifo1_q.size() == 0);
    end

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back({(push_idx % 16 == 15), w});
        push_idx++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ready = 1'b0;
        gap   = 1'b0;
        fifo_q.delete();
        fifo1_q.delete();
        exp_q.delete();
        push_idx = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) push_word(W'(i + 1));
        ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if ({rd_en, valid, last, data, pkt} !== '0)
                $display("FAIL reset_outputs cyc %0d got rd_en=%b valid=%b last=%b data=%h pkt=%0d exp all 0",
                         cyc, rd_en, valid, last, data, pkt);
            else n_pass++;
        end
    endtask

    task automatic test_streaming();
        int first_rd = -1, first_v = -1, first_hs = -1, last_hs = -1, nrx = 0;
        logic [EW-1:0] expv;
        do_reset();
        for (int i = 0; i < 16; i++) push_word(W'(i + 1));
        ready = 1'b1;
        for (int c = 0; c < 80 && nrx < 16; c++) begin
            @(negedge clk);
            if (rd_en && first_rd < 0) first_rd = cyc;
            if (valid && first_v < 0) first_v = cyc;
            if (valid && ready) begin
                expv = exp_q.pop_front();
                n_checks++;
                if ({last, data} !== expv)
                    $display("FAIL stream_beat%0d got last=%b data=%h exp last=%b data=%h", nrx, last, data, expv[W], expv[W-1:0]);
                else n_pass++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                nrx++;
            end
        end
        n_checks++;
        if (nrx !== 16) $display("FAIL stream_count got %0d exp 16", nrx); else n_pass++;
        n_checks++;
        if (first_v - first_rd !== 2) $display("FAIL stream_latency got %0d exp 2", first_v - first_rd); else n_pass++;
        n_checks++;
        if (last_hs - first_hs !== 15) $display("FAIL stream_consecutive got span %0d exp 15", last_hs - first_hs); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (pkt !== 16'd1) $display("FAIL stream_pkt_cnt got %0d exp 1", pkt); else n_pass++;
    endtask

    task automatic test_backpressure();
        int nrx = 0;
        logic [EW-1:0] expv;
        do_reset();
        for (int i = 0; i < 16; i++) push_word(W'(i + 1));
        rd_pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 6) begin
                n_checks++;
                if (!(valid === 1'b1 && data === W'(1) && last === 1'b0))
                    $display("FAIL bp_hold cyc %0d got valid=%b data=%h last=%b exp 1/1/0", cyc, valid, data, last);
                else n_pass++;
            end
        end
        n_checks++;
        if (rd_pulses !== 3 || rd_en !== 1'b0)
            $display("FAIL bp_rd_pulses got %0d (rd_en=%b) exp 3 (rd_en=0)", rd_pulses, rd_en);
        else n_pass++;
        for (int c = 0; c < 80 && nrx < 16; c++) begin
            @(negedge clk);
            ready = 1'b1;
            if (valid) begin
                expv = exp_q.pop_front();
                n_checks++;
                if ({last, data} !== expv)
                    $display("FAIL bp_beat%0d got last=%b data=%h exp last=%b data=%h", nrx, last, data, expv[W], expv[W-1:0]);
                else n_pass++;
                nrx++;
            end
        end
        @(negedge clk);
        ready = 1'b0;
        n_checks++;
        if (nrx !== 16 || pkt !== 16'd1) $display("FAIL bp_done got beats=%0d pkt=%0d exp 16/1", nrx, pkt); else n_pass++;
    endtask

    task automatic test_random();
        int nrx = 0, pushed = 0, errs = 0;
        logic prev_hold = 1'b0;
        logic [EW-1:0] prev_got = '0;
        logic [EW-1:0] expv;
        do_reset();
        rd_while_empty = 0;
        over_cnt = 0;
        for (int c = 0; c < 4000 && nrx < 64; c++) begin
            @(negedge clk);
            ready = 1'($urandom_range(0, 1));
            gap   = ($urandom_range(0, 3) == 0);
            if (pushed < 64 && $urandom_range(0, 2) != 0) begin
                push_word(W'($urandom_range(0, 15)));
                pushed++;
            end
            if (prev_hold && (valid !== 1'b1 || {last, data} !== prev_got)) errs++;
            if (valid && ready) begin
                if (exp_q.size() == 0) expv = 'x; else expv = exp_q.pop_front();
                n_checks++;
                if ({last, data} !== expv)
                    $display("FAIL rand_beat%0d got last=%b data=%h exp last=%b data=%h", nrx, last, data, expv[W], expv[W-1:0]);
                else n_pass++;
                nrx++;
            end
            prev_hold = valid && !ready;
            prev_got  = {last, data};
        end
        @(negedge clk);
        ready = 1'b0;
        gap   = 1'b0;
        n_checks++;
        if (nrx !== 64) $display("FAIL rand_count got %0d exp 64", nrx); else n_pass++;
        n_checks++;
        if (errs !== 0) $display("FAIL rand_hold_stable got %0d violations exp 0", errs); else n_pass++;
        n_checks++;
        if (rd_while_empty !== 0) $display("FAIL rand_rd_while_empty got %0d exp 0", rd_while_empty); else n_pass++;
        n_checks++;
        if (over_cnt !== 0) $display("FAIL rand_overflow got %0d exp 0", over_cnt); else n_pass++;
        n_checks++;
        if (pkt !== 16'd4) $display("FAIL rand_pkt_cnt got %0d exp 4", pkt); else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        int nrx = 0;
        logic [EW-1:0] expv;
        do_reset();
        for (int i = 0; i < 32; i++) push_word(W'(i + 3));
        for (int c = 0; c < 80 && nrx < 5; c++) begin
            @(negedge clk);
            ready = 1'b1;
            if (valid) begin
                expv = exp_q.pop_front();
                n_checks++;
                if ({last, data} !== expv)
                    $display("FAIL mid_pre_beat%0d got %h exp %h", nrx, {last, data}, expv);
                else n_pass++;
                nrx++;
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        ready = 1'b0;
        #1;
        n_checks++;
        if ({rd_en, valid, last, data, pkt} !== '0)
            $display("FAIL mid_reset_outputs got rd_en=%b valid=%b last=%b data=%h pkt=%0d exp all 0", rd_en, valid, last, data, pkt);
        else n_pass++;
        // Words still in the FIFO survive; everything the bridge held is gone.
        exp_q.delete();
        push_idx = 0;
        for (int i = 0; i < fifo_q.size(); i++) begin
            exp_q.push_back({(push_idx % 16 == 15), fifo_q[i]});
            push_idx++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nrx = 0;
        for (int c = 0; c < 80 && nrx < 16; c++) begin
            @(negedge clk);
            ready = 1'b1;
            if (valid) begin
                expv = exp_q.pop_front();
                n_checks++;
                if ({last, data} !== expv)
                    $display("FAIL mid_post_beat%0d got last=%b data=%h exp last=%b data=%h", nrx, last, data, expv[W], expv[W-1:0]);
                else n_pass++;
                nrx++;
            end
        end
        @(negedge clk);
        ready = 1'b0;
        n_checks++;
        if (nrx !== 16 || pkt !== 16'd1) $display("FAIL mid_post_done got beats=%0d pkt=%0d exp 16/1", nrx, pkt); else n_pass++;
    endtask

    task automatic test_pkt_len1();
        int nrx = 0;
        logic [EW-1:0] expv;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fifo1_q.push_back(W'(i + 9));
            exp_q.push_back({1'b1, W'(i + 9)});
        end
        for (int c = 0; c < 40 && nrx < 4; c++) begin
            @(negedge clk);
            if (valid1 && ready1) begin
                expv = exp_q.pop_front();
                n_checks++;
                if ({last1, data1} !== expv)
                    $display("FAIL len1_beat%0d got last=%b data=%h exp last=%b data=%h", nrx, last1, data1, expv[W], expv[W-1:0]);
                else n_pass++;
                nrx++;
            end
        end
        @(negedge clk);
        n_checks++;
        if (nrx !== 4 || pkt1 !== 16'd4) $display("FAIL len1_done got beats=%0d pkt=%0d exp 4/4", nrx, pkt1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_reset_mid_packet();
        test_pkt_len1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
